imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive contended cycles debug may lose before a forced debug grant.
REQ-002 Parameter DEPTH_BITS, default 6: word-address width of the instruction memory (64 words).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clrn  input  1  asynchronous, active-low reset.
REQ-005 f_req  input  1  CPU fetch request; f_addr held stable while f_req=1 and f_gnt=0.
REQ-006 f_addr  input  32  CPU fetch byte address.
REQ-007 f_gnt  output  1  fetch granted this cycle.
REQ-008 f_valid  output  1  fetch response valid, one cycle after f_gnt.
REQ-009 f_inst  output  32  fetch response word.
REQ-010 f_err  output  1  fetch response error: misaligned or out-of-range address.
REQ-011 d_req, d_addr, d_gnt, d_valid, d_inst, d_err  same directions/widths as the f_* ports  debug/loader read port.
REQ-012 mem_a  output  32  byte address to the instruction ROM; word index is mem_a[DEPTH_BITS+1:2].
REQ-013 mem_inst  input  32  combinational ROM read data for mem_a.

Function
REQ-014 At most one of f_gnt/d_gnt SHALL be 1 in any cycle; grants are combinational from f_req, d_req and registered state.
REQ-015 Priority: fetch wins contention unless starve_cnt==STARVE_MAX, in which case debug wins.
REQ-016 starve_cnt (3 bits, saturating at STARVE_MAX) SHALL increment when f_req&d_req&f_gnt, and clear when d_gnt=1 or d_req=0.
REQ-017 A lone requester SHALL be granted in the same cycle it requests.
REQ-018 mem_a SHALL equal the granted requester's address; 32'h0 when no grant.
REQ-019 FSM state register, updated each edge from the current grant: IDLE (no grant), FRESP (fetch granted), DRESP (debug granted).
REQ-020 In FRESP: f_valid=1, d_valid=0; in DRESP: d_valid=1, f_valid=0; in IDLE: both 0.
REQ-021 Response data SHALL be mem_inst registered on the grant edge; latency grant-to-valid exactly 1 cycle; back-to-back grants yield valid every cycle.
REQ-022 Address error = addr[1:0]!=0 or addr[31:DEPTH_BITS+2]!=0; such a request SHALL still be granted, the response SHALL have err=1 and inst=32'h0.
REQ-023 f_inst/f_err and d_inst/d_err SHALL hold their last response value while the corresponding valid is 0.
REQ-024 Request dropped after grant: response still issued one cycle later; no cancellation.
REQ-025 Requester deasserting req before grant: no response issued, starve_cnt rules of REQ-016 apply.
REQ-026 Only the grants and mem_a may depend combinationally on req/addr inputs; valid, inst and err SHALL be register outputs.

Reset
REQ-027 clrn=0 SHALL immediately force state=IDLE, starve_cnt=0, f_valid=d_valid=0, f_inst=d_inst=0, f_err=d_err=0, independent of clk.
REQ-028 While clrn=0, f_gnt=d_gnt=0 and mem_a=0; a grant in flight when reset asserts produces no response.
REQ-029 First grant possible in the first cycle with clrn=1; first valid on the following edge.

Verification
REQ-030 ROM model word0=32'h3C03C000, word1=32'h3C04A000, word25=32'h AC650000; f_req=1, f_addr=0 -> f_gnt same cycle; next cycle f_valid=1, f_inst=32'h3C03C000, f_err=0.
REQ-031 f_req held with f_addr 0,4,8 on consecutive cycles -> f_valid=1 on three consecutive cycles with words 0,1,2 in order.
REQ-032 f_req and d_req=1 continuously, d_addr=32'h64 -> fetch granted 4 cycles, debug granted on the 5th, d_inst=32'hAC650000 one cycle later, starve_cnt back to 0.
REQ-033 d_req=1, d_addr=32'h2 -> d_valid=1, d_err=1, d_inst=0; d_addr=32'h100 -> same; f_* outputs unchanged.
REQ-034 clrn pulsed low mid-cycle after a fetch grant -> f_valid stays 0, f_inst=0 immediately; after release f_req at addr 4 -> f_inst=32'h3C04A000 one cycle after grant.
REQ-035 Bench checks every cycle: never f_gnt&d_gnt, valid exactly one cycle after each grant, mem_a=0 when idle.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Instruction-memory arbiter bus: a CPU fetch port, a debug/loader read
// port and the address/data pair towards the instruction ROM.
interface imem_arbiter_if;
  // fetch port
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_valid;
  logic [31:0] f_inst;
  logic        f_err;
  // debug/loader port
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_inst;
  logic        d_err;
  // instruction ROM side
  logic [31:0] mem_a;
  logic [31:0] mem_inst;

  // Requesters and the ROM model drive this side of the bus
  modport master (
    output f_req, f_addr, d_req, d_addr, mem_inst,
    input  f_gnt, f_valid, f_inst, f_err,
    input  d_gnt, d_valid, d_inst, d_err, mem_a
  );

  // The arbiter itself
  modport slave (
    input  f_req, f_addr, d_req, d_addr, mem_inst,
    output f_gnt, f_valid, f_inst, f_err,
    output d_gnt, d_valid, d_inst, d_err, mem_a
  );
endinterface

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of a combinational instruction ROM.
// Fetch normally wins; debug is forced through after STARVE_MAX lost
// contended cycles. Responses (valid/inst/err) are registered one cycle
// after the grant and hold their value between responses.
module imem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int DEPTH_BITS = 6
) (
  input logic          clk,
  input logic          clrn,
  imem_arbiter_if.slave bus
);

  // One-hot-style encoding so the valid outputs are straight flop bits
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FRESP = 2'b01,
    DRESP = 2'b10
  } state_t;

  localparam logic [2:0]  STARVE_LIM = 3'(STARVE_MAX);
  localparam logic [31:0] HIGH_MASK  = ~((32'h1 << (DEPTH_BITS + 2)) - 32'h1);

  state_t      state;
  logic [2:0]  starve_cnt;
  logic        f_gnt_c;
  logic        d_gnt_c;
  logic        debug_pri;
  logic        sel_bad;
  logic [31:0] sel_addr;

  // Grant decision: lone requester wins at once, contention goes to fetch
  // unless debug has been starved long enough; nothing is granted in reset
  always_comb begin
    debug_pri = (starve_cnt == STARVE_LIM);
    f_gnt_c   = 1'b0;
    d_gnt_c   = 1'b0;
    if (clrn) begin
      if (bus.f_req && bus.d_req) begin
        if (debug_pri) d_gnt_c = 1'b1;
        else           f_gnt_c = 1'b1;
      end else begin
        f_gnt_c = bus.f_req;
        d_gnt_c = bus.d_req;
      end
    end
  end

  // Route the winner's address to the ROM and flag misaligned/out-of-range
  always_comb begin
    sel_addr = 32'h0;
    if (f_gnt_c)      sel_addr = bus.f_addr;
    else if (d_gnt_c) sel_addr = bus.d_addr;
    sel_bad = (sel_addr[1:0] != 2'b00) || ((sel_addr & HIGH_MASK) != 32'h0);
  end

  assign bus.f_gnt   = f_gnt_c;
  assign bus.d_gnt   = d_gnt_c;
  assign bus.mem_a   = sel_addr;
  assign bus.f_valid = state[0];
  assign bus.d_valid = state[1];

  // Response FSM: state follows the grant, response data captured on the
  // grant edge, starvation counter tracks debug losses under contention
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      starve_cnt <= 3'd0;
      bus.f_inst <= 32'h0;
      bus.f_err  <= 1'b0;
      bus.d_inst <= 32'h0;
      bus.d_err  <= 1'b0;
    end else begin
      if (f_gnt_c)      state <= FRESP;
      else if (d_gnt_c) state <= DRESP;
      else              state <= IDLE;

      if (f_gnt_c) begin
        bus.f_inst <= sel_bad ? 32'h0 : bus.mem_inst;
        bus.f_err  <= sel_bad;
      end
      if (d_gnt_c) begin
        bus.d_inst <= sel_bad ? 32'h0 : bus.mem_inst;
        bus.d_err  <= sel_bad;
      end

      if (!bus.d_req || d_gnt_c) begin
        starve_cnt <= 3'd0;
      end else if (f_gnt_c && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: ROM model, fetch/debug sequences,
// starvation override, address errors and asynchronous reset.
module tb_imem_arbiter;

  logic clk;
  logic clrn;
  int   checks;
  int   errors;

  logic [31:0] rom [64];

  imem_arbiter_if bus ();

  imem_arbiter #(.STARVE_MAX(4), .DEPTH_BITS(6)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  // Combinational instruction ROM, word index from mem_a[7:2]
  assign bus.mem_inst = rom[bus.mem_a[7:2]];

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expected value
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive both request ports and let the combinational grant settle
  task automatic applyStimulus(input logic fr, input logic [31:0] fa,
                               input logic dr, input logic [31:0] da);
    bus.f_req  = fr;
    bus.f_addr = fa;
    bus.d_req  = dr;
    bus.d_addr = da;
    #1;
  endtask

  // Advance one cycle with the per-cycle invariants: exclusive grants,
  // idle address zero, and valid exactly one cycle after each grant
  task automatic tick();
    logic pf;
    logic pd;
    pf = bus.f_gnt;
    pd = bus.d_gnt;
    checkOutput("gnt_mutex", {31'b0, pf & pd}, 32'h0);
    if (!pf && !pd) checkOutput("idle_mem_a", bus.mem_a, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("f_valid_lat", {31'b0, bus.f_valid}, {31'b0, pf});
    checkOutput("d_valid_lat", {31'b0, bus.d_valid}, {31'b0, pd});
  endtask

  // Directed sequence
  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + 32'(i);
    rom[0]  = 32'h3C03C000;
    rom[1]  = 32'h3C04A000;
    rom[25] = 32'hAC650000;

    // reset state, with a fetch request pending that must not be granted
    clrn = 1'b0;
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0);
    checkOutput("rst_f_gnt",   {31'b0, bus.f_gnt},   32'h0);
    checkOutput("rst_mem_a",   bus.mem_a,            32'h0);
    checkOutput("rst_f_valid", {31'b0, bus.f_valid}, 32'h0);
    checkOutput("rst_f_inst",  bus.f_inst,           32'h0);
    checkOutput("rst_d_inst",  bus.d_inst,           32'h0);
    checkOutput("rst_d_err",   {31'b0, bus.d_err},   32'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    clrn = 1'b1;
    #1;

    // single fetch of word 0
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0);
    checkOutput("f0_gnt", {31'b0, bus.f_gnt}, 32'h1);
    checkOutput("f0_mem_a", bus.mem_a, 32'h0);
    tick();
    checkOutput("f0_inst", bus.f_inst, 32'h3C03C000);
    checkOutput("f0_err",  {31'b0, bus.f_err}, 32'h0);

    // back-to-back fetches of words 0, 1, 2
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("seq0_inst", bus.f_inst, 32'h3C03C000);
    applyStimulus(1'b1, 32'h4, 1'b0, 32'h0);
    checkOutput("seq1_mem_a", bus.mem_a, 32'h4);
    tick();
    checkOutput("seq1_inst", bus.f_inst, 32'h3C04A000);
    applyStimulus(1'b1, 32'h8, 1'b0, 32'h0);
    tick();
    checkOutput("seq2_inst", bus.f_inst, 32'h1000_0002);

    // idle: response held while valid is low
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("hold_f_inst", bus.f_inst, 32'h1000_0002);

    // contention: fetch wins four times, then debug is forced through
    applyStimulus(1'b1, 32'h0, 1'b1, 32'h64);
    for (int i = 0; i < 4; i++) begin
      checkOutput("starve_f_gnt", {31'b0, bus.f_gnt}, 32'h1);
      checkOutput("starve_d_gnt", {31'b0, bus.d_gnt}, 32'h0);
      tick();
    end
    checkOutput("forced_d_gnt", {31'b0, bus.d_gnt}, 32'h1);
    checkOutput("forced_f_gnt", {31'b0, bus.f_gnt}, 32'h0);
    checkOutput("forced_mem_a", bus.mem_a, 32'h64);
    tick();
    checkOutput("forced_d_inst", bus.d_inst, 32'hAC650000);
    checkOutput("forced_d_err",  {31'b0, bus.d_err}, 32'h0);
    checkOutput("starve_clear",  {29'b0, dut.starve_cnt}, 32'h0);
    checkOutput("after_f_gnt",   {31'b0, bus.f_gnt}, 32'h1);

    // debug gives up before being granted: no debug response
    applyStimulus(1'b1, 32'h4, 1'b0, 32'h0);
    tick();
    checkOutput("drop_f_inst", bus.f_inst, 32'h3C04A000);

    // debug address errors; fetch outputs untouched
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h2);
    checkOutput("mis_d_gnt", {31'b0, bus.d_gnt}, 32'h1);
    tick();
    checkOutput("mis_d_err",  {31'b0, bus.d_err}, 32'h1);
    checkOutput("mis_d_inst", bus.d_inst, 32'h0);
    checkOutput("mis_f_inst", bus.f_inst, 32'h3C04A000);
    checkOutput("mis_f_err",  {31'b0, bus.f_err}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h100);
    tick();
    checkOutput("oor_d_err",  {31'b0, bus.d_err}, 32'h1);
    checkOutput("oor_d_inst", bus.d_inst, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hFC);
    tick();
    checkOutput("top_d_err",  {31'b0, bus.d_err}, 32'h0);
    checkOutput("top_d_inst", bus.d_inst, 32'h1000_003F);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    // fetch error on an out-of-range address
    applyStimulus(1'b1, 32'h4000_0000, 1'b0, 32'h0);
    tick();
    checkOutput("oor_f_err",  {31'b0, bus.f_err}, 32'h1);
    checkOutput("oor_f_inst", bus.f_inst, 32'h0);

    // asynchronous reset with a fetch grant in flight
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("pre_rst_inst", bus.f_inst, 32'h3C03C000);
    checkOutput("pre_rst_gnt", {31'b0, bus.f_gnt}, 32'h1);
    #1;
    clrn = 1'b0;
    #1;
    checkOutput("arst_f_gnt",   {31'b0, bus.f_gnt},   32'h0);
    checkOutput("arst_mem_a",   bus.mem_a,            32'h0);
    checkOutput("arst_f_valid", {31'b0, bus.f_valid}, 32'h0);
    checkOutput("arst_f_inst",  bus.f_inst,           32'h0);
    @(posedge clk);
    #1;
    checkOutput("arst_hold_valid", {31'b0, bus.f_valid}, 32'h0);
    checkOutput("arst_hold_inst",  bus.f_inst,           32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    clrn = 1'b1;
    #1;
    applyStimulus(1'b1, 32'h4, 1'b0, 32'h0);
    checkOutput("post_rst_gnt", {31'b0, bus.f_gnt}, 32'h1);
    tick();
    checkOutput("post_rst_inst", bus.f_inst, 32'h3C04A000);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
